// File: rtl/mii_net_pkg.sv
// Shared types and constants for the MII receive frame path.
package mii_net_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_DATA,
    ST_DROP,
    ST_COMMIT
  } rx_state_t;

  localparam int MIN_BYTES_DEF = 64;
  localparam int MAX_BYTES_DEF = 1518;
  localparam int NUM_SLOTS     = 2;
  localparam int LEN_W         = 11;

  typedef struct packed {
    logic             slot;
    logic [LEN_W-1:0] len;
  } rx_desc_t;

endpackage

// File: rtl/mii_rx_desc_fifo.sv
// Two-entry descriptor queue; head entry is presented with valid/ready.
module mii_rx_desc_fifo
  import mii_net_pkg::*;
(
  input  logic     enet_rx_clk,
  input  logic     i_reset,
  input  logic     push,
  input  rx_desc_t push_desc,
  input  logic     i_ready,
  output logic     o_valid,
  output rx_desc_t o_desc
);

  logic [1:0] count;
  rx_desc_t   head;
  rx_desc_t   tail;
  logic       pop;
  logic       push_ok;

  assign o_valid = (count != 2'd0);
  assign o_desc  = head;
  assign pop     = o_valid & i_ready;
  // A full queue only accepts a push when the head leaves in the same cycle.
  assign push_ok = push & ((count != 2'd2) | pop);

  always_ff @(posedge enet_rx_clk) begin
    if (i_reset) begin
      count <= 2'd0;
      head  <= '0;
      tail  <= '0;
    end else begin
      case ({push_ok, pop})
        2'b11: begin
          if (count == 2'd1) begin
            head <= push_desc;
          end else begin
            head <= tail;
            tail <= push_desc;
          end
        end
        2'b01: begin
          head  <= tail;
          count <= count - 2'd1;
        end
        2'b10: begin
          if (count == 2'd0) head <= push_desc;
          else               tail <= push_desc;
          count <= count + 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mii_rx_frame_ctrl.sv
// MII nibble receiver: strips preamble, writes frame bytes into a two-slot
// frame RAM and hands completed good frames to the consumer as descriptors.
module mii_rx_frame_ctrl
  import mii_net_pkg::*;
#(
  parameter int MIN_BYTES = MIN_BYTES_DEF,
  parameter int MAX_BYTES = MAX_BYTES_DEF
) (
  input  logic        enet_rx_clk,
  input  logic        i_reset,
  input  logic        i_enable,
  input  logic        enet_rx_dv,
  input  logic        enet_rx_er,
  input  logic [3:0]  enet_rx_data,
  output logic        o_wr_en,
  output logic [11:0] o_wr_addr,
  output logic [7:0]  o_wr_data,
  output logic        o_desc_valid,
  input  logic        i_desc_ready,
  output logic        o_desc_slot,
  output logic [10:0] o_desc_len,
  input  logic        i_release,
  input  logic        i_release_slot,
  output logic [15:0] o_frame_count,
  output logic [15:0] o_drop_count
);

  localparam logic [LEN_W-1:0] MIN_LEN = LEN_W'(MIN_BYTES);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BYTES);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  rx_state_t            state;
  logic [NUM_SLOTS-1:0] busy;
  logic [NUM_SLOTS-1:0] busy_nxt;
  logic                 cur_slot;
  logic [LEN_W-1:0]     byte_idx;
  logic                 nib_odd;
  logic                 bad;
  logic [3:0]           nib_lo_p0;

  logic                 sfd_hit;
  logic                 alloc_go;
  logic                 alloc_slot;
  logic                 over_len;
  logic                 frame_ok;
  logic                 commit_push;
  logic                 free_go;
  rx_desc_t             push_desc;
  rx_desc_t             desc_head;

  always_comb begin
    sfd_hit     = (state == ST_PREAMBLE) && enet_rx_dv && (enet_rx_data == 4'hD);
    alloc_slot  = busy[0];
    alloc_go    = sfd_hit && i_enable && !(&busy);
    over_len    = (state == ST_DATA) && enet_rx_dv && (byte_idx == MAX_LEN);
    frame_ok    = (byte_idx >= MIN_LEN) && (byte_idx <= MAX_LEN) && !nib_odd && !bad;
    commit_push = (state == ST_COMMIT) && frame_ok;
    free_go     = ((state == ST_COMMIT) && !frame_ok) || over_len;
    push_desc   = '{slot: cur_slot, len: byte_idx};
    // Allocation looks at the current flags, so a same-cycle release is not visible to it.
    busy_nxt = busy;
    if (i_release) busy_nxt[i_release_slot] = 1'b0;
    if (alloc_go)  busy_nxt[alloc_slot]     = 1'b1;
    if (free_go)   busy_nxt[cur_slot]       = 1'b0;
  end

  // Stage p0: low nibble of the byte under assembly
  always_ff @(posedge enet_rx_clk) begin
    if ((state == ST_DATA) && enet_rx_dv && !nib_odd) nib_lo_p0 <= enet_rx_data;
  end

  always_ff @(posedge enet_rx_clk) begin
    if (i_reset) begin
      state         <= ST_IDLE;
      busy          <= '0;
      cur_slot      <= 1'b0;
      byte_idx      <= '0;
      nib_odd       <= 1'b0;
      bad           <= 1'b0;
      o_wr_en       <= 1'b0;
      o_wr_addr     <= '0;
      o_wr_data     <= '0;
      o_frame_count <= '0;
      o_drop_count  <= '0;
    end else begin
      busy    <= busy_nxt;
      o_wr_en <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (enet_rx_dv) state <= ST_PREAMBLE;
        end
        ST_PREAMBLE: begin
          if (!enet_rx_dv) begin
            state <= ST_IDLE;
          end else begin
            case (enet_rx_data)
              4'h5: state <= ST_PREAMBLE;
              4'hD: begin
                if (alloc_go) begin
                  cur_slot <= alloc_slot;
                  byte_idx <= '0;
                  nib_odd  <= 1'b0;
                  bad      <= 1'b0;
                  state    <= ST_DATA;
                end else begin
                  state        <= ST_DROP;
                  o_drop_count <= sat_inc16(o_drop_count);
                end
              end
              default: state <= ST_DROP;
            endcase
          end
        end
        ST_DATA: begin
          if (enet_rx_er) bad <= 1'b1;
          if (!enet_rx_dv) begin
            state <= ST_COMMIT;
          end else if (over_len) begin
            state        <= ST_DROP;
            o_drop_count <= sat_inc16(o_drop_count);
          end else if (!nib_odd) begin
            nib_odd <= 1'b1;
          end else begin
            // Stage p1: completed byte goes to the frame RAM
            nib_odd   <= 1'b0;
            o_wr_en   <= 1'b1;
            o_wr_addr <= {cur_slot, byte_idx};
            o_wr_data <= {enet_rx_data, nib_lo_p0};
            byte_idx  <= byte_idx + 1'b1;
          end
        end
        ST_COMMIT: begin
          state <= ST_IDLE;
          if (frame_ok) o_frame_count <= o_frame_count + 16'd1;
          else          o_drop_count  <= sat_inc16(o_drop_count);
        end
        ST_DROP: begin
          if (!enet_rx_dv) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  mii_rx_desc_fifo u_desc_fifo (
    .enet_rx_clk (enet_rx_clk),
    .i_reset     (i_reset),
    .push        (commit_push),
    .push_desc   (push_desc),
    .i_ready     (i_desc_ready),
    .o_valid     (o_desc_valid),
    .o_desc      (desc_head)
  );

  assign o_desc_slot = desc_head.slot;
  assign o_desc_len  = desc_head.len;

endmodule

// File: tb/tb_mii_rx_frame_ctrl.sv
// Scoreboard bench for mii_rx_frame_ctrl: expected writes and descriptors are
// queued as frames are driven and popped when the DUT produces them.
module tb_mii_rx_frame_ctrl;

  logic        enet_rx_clk = 1'b0;
  logic        i_reset;
  logic        i_enable;
  logic        enet_rx_dv;
  logic        enet_rx_er;
  logic [3:0]  enet_rx_data;
  logic        o_wr_en;
  logic [11:0] o_wr_addr;
  logic [7:0]  o_wr_data;
  logic        o_desc_valid;
  logic        i_desc_ready;
  logic        o_desc_slot;
  logic [10:0] o_desc_len;
  logic        i_release;
  logic        i_release_slot;
  logic [15:0] o_frame_count;
  logic [15:0] o_drop_count;

  int n_checks = 0;
  int n_errors = 0;
  int exp_frames = 0;
  int exp_drops = 0;
  logic [19:0] wr_q[$];
  logic [11:0] desc_q[$];

  always #5 enet_rx_clk = ~enet_rx_clk;

  mii_rx_frame_ctrl dut (
    .enet_rx_clk    (enet_rx_clk),
    .i_reset        (i_reset),
    .i_enable       (i_enable),
    .enet_rx_dv     (enet_rx_dv),
    .enet_rx_er     (enet_rx_er),
    .enet_rx_data   (enet_rx_data),
    .o_wr_en        (o_wr_en),
    .o_wr_addr      (o_wr_addr),
    .o_wr_data      (o_wr_data),
    .o_desc_valid   (o_desc_valid),
    .i_desc_ready   (i_desc_ready),
    .o_desc_slot    (o_desc_slot),
    .o_desc_len     (o_desc_len),
    .i_release      (i_release),
    .i_release_slot (i_release_slot),
    .o_frame_count  (o_frame_count),
    .o_drop_count   (o_drop_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge enet_rx_clk) begin
    logic [19:0] we;
    logic [11:0] de;
    if (o_wr_en) begin
      if (wr_q.size() == 0) begin
        chk("wr_unexpected", 32'(o_wr_en), 32'd0);
      end else begin
        we = wr_q.pop_front();
        chk("wr_addr", 32'(o_wr_addr), 32'(we[19:8]));
        chk("wr_data", 32'(o_wr_data), 32'(we[7:0]));
      end
    end
    if (o_desc_valid && i_desc_ready) begin
      if (desc_q.size() == 0) begin
        chk("desc_unexpected", 32'(o_desc_valid), 32'd0);
      end else begin
        de = desc_q.pop_front();
        chk("desc_slot", 32'(o_desc_slot), 32'(de[11]));
        chk("desc_len", 32'(o_desc_len), 32'(de[10:0]));
      end
    end
  end

  task automatic nib(input logic dv, input logic er, input logic [3:0] d);
    enet_rx_dv   = dv;
    enet_rx_er   = er;
    enet_rx_data = d;
    @(posedge enet_rx_clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) nib(1'b0, 1'b0, 4'h0);
  endtask

  task automatic preamble();
    for (int i = 0; i < 15; i++) nib(1'b1, 1'b0, 4'h5);
    nib(1'b1, 1'b0, 4'hD);
  endtask

  // Drives one frame; enable is flipped right after the SFD to show it has no mid-frame effect.
  task automatic send_frame(input int nbytes, input int er_byte, input logic en,
                            input logic dribble, input logic exp_wr,
                            input logic exp_slot, input logic exp_ok);
    logic [7:0] b;
    i_enable = en;
    preamble();
    i_enable = ~en;
    for (int i = 0; i < nbytes; i++) begin
      b = 8'(i);
      nib(1'b1, (i == er_byte), b[3:0]);
      nib(1'b1, 1'b0, b[7:4]);
      if (exp_wr && i < 1518) wr_q.push_back({exp_slot, 11'(i), b});
    end
    if (dribble) nib(1'b1, 1'b0, 4'h6);
    if (exp_ok) begin
      desc_q.push_back({exp_slot, 11'(nbytes)});
      exp_frames++;
    end else begin
      exp_drops++;
    end
    i_enable = 1'b1;
    idle(8);
  endtask

  task automatic release_slot(input logic s);
    i_release      = 1'b1;
    i_release_slot = s;
    @(posedge enet_rx_clk);
    #1;
    i_release      = 1'b0;
    i_release_slot = 1'b0;
  endtask

  task automatic chk_counts(input string tag);
    chk({tag, "_frames"}, 32'(o_frame_count), 32'(exp_frames));
    chk({tag, "_drops"}, 32'(o_drop_count), 32'(exp_drops));
  endtask

  task automatic chk_drained(input string tag);
    chk_counts(tag);
    chk({tag, "_wrq_left"}, 32'(wr_q.size()), 32'd0);
    chk({tag, "_descq_left"}, 32'(desc_q.size()), 32'd0);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    i_reset = 1'b1; i_enable = 1'b1; i_desc_ready = 1'b1;
    i_release = 1'b0; i_release_slot = 1'b0;
    idle(3);
    i_reset = 1'b0;
    chk("rst_wr_en", 32'(o_wr_en), 32'd0);
    chk("rst_wr_addr", 32'(o_wr_addr), 32'd0);
    chk("rst_wr_data", 32'(o_wr_data), 32'd0);
    chk("rst_desc_valid", 32'(o_desc_valid), 32'd0);
    chk("rst_desc_slot", 32'(o_desc_slot), 32'd0);
    chk("rst_desc_len", 32'(o_desc_len), 32'd0);
    chk_counts("rst");
    idle(2);

    send_frame(64, -1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    chk_drained("good");
    release_slot(1'b0);

    send_frame(40, -1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk_drained("runt");

    send_frame(64, -1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    send_frame(64, -1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    send_frame(64, -1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_drained("exhaust");
    release_slot(1'b0);
    send_frame(64, -1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    chk_drained("after_release");
    release_slot(1'b0);
    release_slot(1'b1);

    send_frame(100, 10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk_drained("rx_er");
    send_frame(1519, -1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk_drained("too_long");
    send_frame(64, -1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk_drained("dribble");
    send_frame(63, -1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk_drained("min_minus1");
    send_frame(1518, -1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    chk_drained("max_len");
    release_slot(1'b0);
    send_frame(64, -1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_drained("disabled");

    i_desc_ready = 1'b0;
    send_frame(64, -1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    send_frame(70, -1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    chk_counts("bp");
    chk("bp_hold_valid", 32'(o_desc_valid), 32'd1);
    chk("bp_hold_slot", 32'(o_desc_slot), 32'd0);
    chk("bp_hold_len", 32'(o_desc_len), 32'd64);
    i_desc_ready = 1'b1;
    @(negedge enet_rx_clk);
    chk("bp_pop0_valid", 32'(o_desc_valid), 32'd1);
    chk("bp_pop0_slot", 32'(o_desc_slot), 32'd0);
    @(negedge enet_rx_clk);
    chk("bp_pop1_valid", 32'(o_desc_valid), 32'd1);
    chk("bp_pop1_slot", 32'(o_desc_slot), 32'd1);
    chk("bp_pop1_len", 32'(o_desc_len), 32'd70);
    @(negedge enet_rx_clk);
    chk("bp_empty", 32'(o_desc_valid), 32'd0);
    @(posedge enet_rx_clk);
    #1;
    chk_drained("bp");
    release_slot(1'b0);
    release_slot(1'b1);

    i_enable = 1'b1;
    preamble();
    for (int i = 0; i < 30; i++) begin
      b = 8'(i);
      nib(1'b1, 1'b0, b[3:0]);
      nib(1'b1, 1'b0, b[7:4]);
      wr_q.push_back({1'b0, 11'(i), b});
    end
    i_reset = 1'b1;
    idle(2);
    i_reset = 1'b0;
    exp_frames = 0;
    exp_drops = 0;
    idle(6);
    chk("midrst_desc_valid", 32'(o_desc_valid), 32'd0);
    chk_drained("midrst");
    send_frame(64, -1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    chk_drained("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mii_rx_frame_ctrl.md
MII_RX_FRAME_CTRL -- requirements
Module: mii_rx_frame_ctrl

Interface
REQ-001 Parameter MIN_BYTES, default 64: minimum accepted frame length in bytes, FCS included.
REQ-002 Parameter MAX_BYTES, default 1518: maximum accepted frame length in bytes, must be at most 2047.
REQ-003 enet_rx_clk  in  1  sole clock; all logic SHALL be on its rising edge.
REQ-004 i_reset  in  1  synchronous, active-high reset.
REQ-005 i_enable  in  1  receive enable; sampled only at SFD.
REQ-006 enet_rx_dv  in  1  MII receive data valid.
REQ-007 enet_rx_er  in  1  MII receive error.
REQ-008 enet_rx_data  in  4  MII receive nibble.
REQ-009 o_wr_en  out  1  frame-RAM byte write strobe.
REQ-010 o_wr_addr  out  12  frame-RAM address = {slot, byte_index[10:0]}.
REQ-011 o_wr_data  out  8  frame-RAM write byte.
REQ-012 o_desc_valid / i_desc_ready  out/in  1/1  descriptor handshake.
REQ-013 o_desc_slot  out  1  slot holding the completed frame.
REQ-014 o_desc_len  out  11  frame length in bytes.
REQ-015 i_release / i_release_slot  in/in  1/1  one-cycle pulse that frees a slot after the consumer has read it.
REQ-016 o_frame_count / o_drop_count  out/out  16/16  good-frame count (wraps) and dropped-frame count (saturates at 0xFFFF).

Function
REQ-017 States: IDLE, PREAMBLE, DATA, DROP, COMMIT.
- IDLE→PREAMBLE when dv=1.
REQ-018 PREAMBLE behaviour:
- nibble 0x5 → stay in PREAMBLE.
- nibble 0xD (SFD) → allocate a slot and go to DATA.
- any other nibble → DROP.
- dv=0 → IDLE, no count change.
REQ-019 SFD rejection: if i_enable=0 or no slot is free at SFD, → DROP, o_drop_count increments, nothing is written to the frame RAM.
REQ-020 Byte assembly: first nibble after SFD → byte[3:0], second nibble → byte[7:4]; no bit reversal.
REQ-021 Write timing:
- o_wr_en pulses one cycle, on the cycle after the second nibble.
- Address is {slot, byte_index}; byte_index starts at 0 and increments after each write.
REQ-022 enet_rx_er=1 at any point in DATA → frame marked bad; writes continue.
REQ-023 byte_index reaching MAX_BYTES with dv still high → DROP, no further writes.
REQ-024 dv falling in DATA → COMMIT for one cycle, then IDLE.
REQ-025 COMMIT acceptance:
- Frame accepted only if length ≥ MIN_BYTES, length ≤ MAX_BYTES, no odd trailing nibble (dribble), and no rx_er.
- Accepted: push {slot, len} to the descriptor queue and increment o_frame_count.
- Otherwise: free the slot and increment o_drop_count.
REQ-026 DROP → IDLE when dv=0; one drop count per frame.
REQ-027 Slots:
- Two slots, each with a busy flag.
- Allocation picks the lowest free slot.
- A slot stays busy from SFD until released (or until the frame is dropped at COMMIT).
REQ-028 Release:
- Release takes effect on the next cycle.
- A same-cycle allocation sees the pre-release flags.
- Releasing a free slot is ignored.
REQ-029 Descriptor queue:
- Depth 2, FIFO order; it cannot overflow because it holds at most one entry per slot.
- o_desc_valid rises one cycle after COMMIT.
- Outputs stay stable until valid&ready.
- Pop and push in the same cycle are both honoured.
REQ-030 i_enable changing mid-frame has no effect on the current frame.

Reset
REQ-031 i_reset SHALL take priority over all other inputs on any cycle, including mid-frame. On reset:
- state IDLE, both slots free, queue empty;
- o_wr_en=0, o_desc_valid=0, o_wr_addr=0, o_wr_data=0, o_desc_slot=0, o_desc_len=0;
- both counters 0.
REQ-032 A frame in progress at reset SHALL be discarded without counting; dv still high after reset SHALL be handled as a new frame and fail the preamble check unless a valid preamble follows.

Structure
REQ-033 The package mii_net_pkg SHALL hold:
- the state enum;
- the MIN_BYTES and MAX_BYTES defaults;
- the slot-count constant (2);
- the descriptor struct {slot, len}.
REQ-034 The descriptor queue SHALL be the sub-module mii_rx_desc_fifo (depth 2, valid/ready output).

Verification
REQ-035 Good frame: preamble 15×0x5, then 0xD, then 64 bytes 0x00..0x3F → 64 writes, addresses 0x000–0x03F, data equal to the index; descriptor {slot 0, len 64}; o_frame_count=1.
REQ-036 Runt: same preamble, 40 bytes → 40 writes, no descriptor; o_drop_count=1; slot 0 free afterward.
REQ-037 Slot exhaustion: two good 64-byte frames, no release, then a third frame → descriptors for slots 0 and 1; third frame dropped with zero writes; after i_release slot 0, a fourth frame lands at address 0x000.
REQ-038 Errors:
- rx_er pulse at byte 10 of a 100-byte frame → dropped.
- 1519-byte frame → writes stop after byte index 1517; dropped.
- Both cases: o_drop_count increments by 1.
REQ-039 Backpressure: i_desc_ready=0 while two frames complete → o_desc_valid held with the slot-0 descriptor; raise ready → slot 0 then slot 1 descriptors on consecutive cycles.
REQ-040 Reset at byte 30 of a frame → no descriptor; counters 0; next good frame is written to slot 0.
